// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencer for load-use stalls, D-cache freeze with watchdog, redirect flush and halt drain
// Ports: clk/rst (async active-high); id_* ID-stage operand and halt info; ex_* EX-stage load/dest/redirect info;
//        mem_req/dc_done D-cache handshake; stall/nop/flush/DC_Stall pipeline controls; halted/err status; stall_cnt perf counter
module pipe_hazard_ctrl #(
  parameter int DC_TIMEOUT   = 64,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_read1RegSel,
  input  logic [2:0]       id_read2RegSel,
  input  logic             id_uses_r1,
  input  logic             id_uses_r2,
  input  logic             id_halt,
  input  logic             ex_MemRead,
  input  logic             ex_RegWrite,
  input  logic [2:0]       ex_Write_register,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dc_done,
  output logic             stall,
  output logic             nop,
  output logic             flush,
  output logic             DC_Stall,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WW = $clog2(DC_TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [1:0] {RUN, DC_WAIT, DRAIN, HALT} state_t;
  state_t           r_state;
  logic [WW-1:0]    r_wcnt;
  logic [DW-1:0]    r_dcnt;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             w_busy, w_lu, w_eval, w_hold;
  assign w_busy = mem_req & ~dc_done;
  assign w_lu   = ex_MemRead & ex_RegWrite &
                  ((id_uses_r1 & (id_read1RegSel == ex_Write_register)) |
                   (id_uses_r2 & (id_read2RegSel == ex_Write_register)));
  // RUN priority applies in RUN and on the DC_WAIT release cycle, once the freeze is gone
  assign w_eval   = (r_state == RUN || r_state == DC_WAIT) & ~w_busy;
  assign w_hold   = r_state == DRAIN || r_state == HALT;
  assign DC_Stall = w_busy & (r_state != HALT);
  assign flush    = w_eval & ex_redirect;
  assign nop      = (w_eval & (ex_redirect | id_halt | w_lu)) | w_hold;
  assign stall    = (w_eval & ~ex_redirect & (id_halt | w_lu)) | w_hold;
  assign halted   = r_state == HALT;
  assign err      = r_err;
  assign stall_cnt = r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_wcnt  <= '0;
      r_dcnt  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if ((stall | DC_Stall) & ~&r_cnt) r_cnt <= r_cnt + 1'b1;
      if (r_state == RUN || r_state == DC_WAIT) begin
        if (w_busy && r_state == RUN) begin
          r_state <= DC_WAIT;
          r_wcnt  <= WW'(1);
        end else if (w_busy && r_wcnt == WW'(DC_TIMEOUT)) begin
          r_err   <= 1'b1;
          r_state <= HALT;
        end else if (w_busy) begin
          r_wcnt <= r_wcnt + 1'b1;
        end else begin
          r_state <= (id_halt & ~ex_redirect) ? DRAIN : RUN;
          r_dcnt  <= DW'(1);
        end
      end else if (r_state == DRAIN && !w_busy) begin
        if (r_dcnt == DW'(DRAIN_CYCLES)) r_state <= HALT;
        else r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end
endmodule
